// File: rtl/bist_control_param.sv
// Parametrised BIST sequencer: drives pattern-valid, seed-select and phase
// strobes for the pattern generator and signature register of a circuit
// under test, and keeps a registered pass/abort verdict of the last run.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// S_IDLE   | after reset, waiting for start low (stuck-high start guard)
// S_ARMED  | start seen low, waiting for start high
// S_INIT   | one-cycle seed load, counters and verdict cleared
// S_RUN    | pattern rounds in progress (pattern cycles + one gap per round)
// S_FINISH | normal end of run, verdict captured from sig_ok
// S_HOLD   | run ended, waiting for start low
// S_DONE   | run ended, waiting for start high to restart

module bist_control_param #(
    parameter int N          = 9,
    parameter int M          = 100,
    parameter int SEED_ROUND = 14,
    localparam int PW        = $clog2(N + 1),
    localparam int RW        = $clog2(M + 1)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic          abort,
    input  logic          cont,
    input  logic          sig_ok,
    output logic          init,
    output logic          running,
    output logic          out,
    output logic          seed,
    output logic          finish,
    output logic          bist_end,
    output logic          pass,
    output logic          aborted,
    output logic [RW-1:0] round,
    output logic [PW-1:0] pat
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ARMED  = 3'd1,
        S_INIT   = 3'd2,
        S_RUN    = 3'd3,
        S_FINISH = 3'd4,
        S_HOLD   = 3'd5,
        S_DONE   = 3'd6
    } state_t;

    // Position N in a round is the gap cycle; round M-1 is the last round.
    // The seed threshold fits in RW bits because SEED_ROUND never exceeds M.
    localparam logic [PW-1:0] PAT_GAP    = PW'(N);
    localparam logic [RW-1:0] ROUND_LAST = RW'(M - 1);
    localparam logic [RW-1:0] SEED_FIRST = RW'(SEED_ROUND);

    state_t state;

    // Sequencer state, round/pattern counters and the registered verdict.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= S_IDLE;
            pat     <= '0;
            round   <= '0;
            pass    <= 1'b0;
            aborted <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!start)
                        state <= S_ARMED;
                end
                S_ARMED: begin
                    if (start)
                        state <= S_INIT;
                end
                S_INIT: begin
                    pat     <= '0;
                    round   <= '0;
                    pass    <= 1'b0;
                    aborted <= 1'b0;
                    state   <= S_RUN;
                end
                S_RUN: begin
                    // Abort wins over the end-of-run gap so a late abort
                    // never produces a finish strobe.
                    if (abort) begin
                        aborted <= 1'b1;
                        pass    <= 1'b0;
                        state   <= S_HOLD;
                    end else if (pat == PAT_GAP) begin
                        pat <= '0;
                        // The last round stays at M-1 so the counter never wraps.
                        if (round == ROUND_LAST)
                            state <= S_FINISH;
                        else
                            round <= round + RW'(1);
                    end else begin
                        pat <= pat + PW'(1);
                    end
                end
                S_FINISH: begin
                    pass  <= sig_ok;
                    state <= cont ? S_INIT : S_HOLD;
                end
                S_HOLD: begin
                    if (!start)
                        state <= S_DONE;
                end
                S_DONE: begin
                    if (start)
                        state <= S_INIT;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Moore decode of the strobes; unlisted and unreachable states drive 0.
    always_comb begin
        init     = 1'b0;
        running  = 1'b0;
        out      = 1'b0;
        seed     = 1'b0;
        finish   = 1'b0;
        bist_end = 1'b0;
        case (state)
            S_INIT: init = 1'b1;
            S_RUN: begin
                running = 1'b1;
                out     = (pat != PAT_GAP);
                seed    = (pat != PAT_GAP) && (round >= SEED_FIRST);
            end
            S_FINISH: begin
                finish   = 1'b1;
                bist_end = 1'b1;
            end
            S_HOLD:  bist_end = 1'b1;
            S_DONE:  bist_end = 1'b1;
            default: ;
        endcase
    end

endmodule
